// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI responder.
package spi_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;
  localparam int SPI_BITS = 8;
  localparam int SPI_SYNC_DEPTH = 2;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer plus one edge register for rise/fall pulses.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SPI_SYNC_DEPTH:0] sr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sr <= {(SPI_SYNC_DEPTH + 1){INIT}};
    else sr <= {sr[SPI_SYNC_DEPTH-1:0], d};
  assign level = sr[SPI_SYNC_DEPTH-1];
  assign rise = level & ~sr[SPI_SYNC_DEPTH];
  assign fall = ~level & sr[SPI_SYNC_DEPTH];
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled CPOL=0/CPHA=1 SPI responder moving bytes between the bus and external FIFOs.
module spi_slave_rx
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] dout,
  output logic       rx_fifo_wr,
  input  logic       rx_fifo_full,
  input  logic [7:0] din,
  output logic       tx_fifo_rd,
  input  logic       tx_fifo_empty,
  output logic       busy,
  output logic       overflow,
  output logic       underrun,
  input  logic       err_clr
);
  logic cs_s, cs_rise, cs_fall, sck_rise, sck_fall, mosi_s;
  logic sck_level_unused, mosi_rise_unused, mosi_fall_unused;
  logic [1:0] state;
  logic [$clog2(SPI_BITS)-1:0] cnt;
  logic [SPI_BITS-1:0] tx_shift, rx_shift, rx_next;
  logic miso_q, byte_ok, load_ok;

  spi_sync_edge #(.INIT(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(cs), .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.INIT(1'b0)) u_sck (
    .clk(clk), .rst(rst), .d(sck), .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync_edge #(.INIT(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(mosi), .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // a cs rise in the same cycle as the last sck fall discards the byte
  assign rx_next = {rx_shift[SPI_BITS-2:0], mosi_s};
  assign byte_ok = (state == ST_SHIFT) && sck_fall && (cnt == '1) && !cs_rise;
  assign load_ok = (state == ST_LOAD) && !cs_rise;
  assign tx_fifo_rd = load_ok && !tx_fifo_empty;
  assign busy = ~cs_s;
  assign miso = (state == ST_IDLE) ? 1'b1 : miso_q;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      miso_q <= 1'b1;
      dout <= '0;
      rx_fifo_wr <= 1'b0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      rx_fifo_wr <= byte_ok && !rx_fifo_full;
      overflow <= (overflow && !err_clr) || (byte_ok && rx_fifo_full);
      underrun <= (underrun && !err_clr) || (load_ok && tx_fifo_empty);
      if (cs_rise) begin
        state <= ST_IDLE;
        cnt <= '0;
        miso_q <= 1'b1;
      end else if (state == ST_IDLE) begin
        cnt <= '0;
        state <= cs_fall ? ST_LOAD : ST_IDLE;
      end else if (state == ST_LOAD) begin
        tx_shift <= tx_fifo_empty ? SPI_IDLE_BYTE : din;
        state <= ST_SHIFT;
      end else begin
        if (sck_rise) begin
          miso_q <= tx_shift[SPI_BITS-1];
          tx_shift <= {tx_shift[SPI_BITS-2:0], 1'b0};
        end
        if (sck_fall) begin
          rx_shift <= rx_next;
          cnt <= cnt + 1'b1;
        end
        if (byte_ok) begin
          dout <= rx_next;
          state <= ST_LOAD;
        end
      end
    end
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: randomized SPI master plus FIFO models checked against a byte-level reference.
module tb_spi_slave_rx;
  logic clk = 1'b0, rst = 1'b0, cs = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic rx_fifo_full = 1'b0, err_clr = 1'b0;
  logic miso, rx_fifo_wr, tx_fifo_rd, tx_fifo_empty, busy, overflow, underrun;
  logic [7:0] dout, din;
  logic [7:0] tx_mem [0:255];
  int tx_wr = 0, tx_rd = 0, model_rd = 0, h = 4;
  int checks = 0, failures = 0;
  logic [7:0] rxq[$], exp_rxq[$];
  logic [7:0] mb [0:7];
  logic [7:0] exp_dout = 8'h00;
  logic exp_ovf = 1'b0, exp_unr = 1'b0;

  spi_slave_rx dut (
    .clk(clk), .rst(rst), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
    .dout(dout), .rx_fifo_wr(rx_fifo_wr), .rx_fifo_full(rx_fifo_full),
    .din(din), .tx_fifo_rd(tx_fifo_rd), .tx_fifo_empty(tx_fifo_empty),
    .busy(busy), .overflow(overflow), .underrun(underrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  assign tx_fifo_empty = (tx_rd == tx_wr);
  assign din = tx_mem[tx_rd[7:0]];
  always @(posedge clk) if (tx_fifo_rd) tx_rd <= tx_rd + 1;
  always @(posedge clk) if (rx_fifo_wr) rxq.push_back(dout);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_mem[tx_wr[7:0]] = b;
    tx_wr++;
  endtask

  // every pop opportunity yields the next queued byte, or the idle byte plus an underrun
  task automatic model_fetch(output logic [7:0] v);
    if (model_rd < tx_wr) begin
      v = tx_mem[model_rd[7:0]];
      model_rd++;
    end else begin
      v = 8'hFF;
      exp_unr = 1'b1;
    end
  endtask

  task automatic bit_xfer(input logic b, output logic m);
    @(negedge clk);
    sck = 1'b1;
    mosi = b;
    repeat (h) @(negedge clk);
    m = miso;
    sck = 1'b0;
    repeat (h - 1) @(negedge clk);
  endtask

  task automatic check_state();
    check("rx_count", rxq.size(), exp_rxq.size());
    for (int i = 0; i < rxq.size() && i < exp_rxq.size(); i++) check("rx_data", rxq[i], exp_rxq[i]);
    check("dout", dout, exp_dout);
    check("pops", tx_rd, model_rd);
    check("overflow", overflow, exp_ovf);
    check("underrun", underrun, exp_unr);
  endtask

  task automatic check_reset();
    check("rst_miso", miso, 1);
    check("rst_dout", dout, 0);
    check("rst_rx_wr", rx_fifo_wr, 0);
    check("rst_tx_rd", tx_fifo_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unr", underrun, 0);
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_ovf = 1'b0;
    exp_unr = 1'b0;
    @(negedge clk);
    check("clr_ovf", overflow, 0);
    check("clr_unr", underrun, 0);
  endtask

  task automatic txn(input int n, input int part);
    logic [7:0] v, got;
    logic m;
    cs = 1'b0;
    repeat (6) @(negedge clk);
    check("busy", busy, 1);
    for (int k = 0; k < n; k++) begin
      model_fetch(v);
      got = 8'h00;
      for (int i = 0; i < 8; i++) begin
        bit_xfer(mb[k][7-i], m);
        got = {got[6:0], m};
      end
      check("miso_byte", got, v);
      if (rx_fifo_full) exp_ovf = 1'b1;
      else exp_rxq.push_back(mb[k]);
      exp_dout = mb[k];
    end
    model_fetch(v);
    if (part > 0) begin
      got = 8'h00;
      for (int i = 0; i < part; i++) begin
        bit_xfer(mb[n][7-i], m);
        got = {got[6:0], m};
      end
      check("miso_part", got, 32'(v >> (8 - part)));
    end
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    check("miso_idle", miso, 1);
    check("busy_idle", busy, 0);
    check_state();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic m;
    logic [7:0] v;
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);

    push_tx(8'h3C); push_tx(8'h77);
    mb[0] = 8'hA5;
    txn(1, 0);
    check("single_pops", tx_rd, 2);

    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33); push_tx(8'h44);
    mb[0] = 8'h01; mb[1] = 8'h02; mb[2] = 8'h03;
    txn(3, 0);

    mb[0] = 8'($urandom);
    txn(1, 0);
    check("empty_unr", underrun, 1);
    clear_err();

    push_tx(8'($urandom)); push_tx(8'($urandom));
    rx_fifo_full = 1'b1;
    mb[0] = 8'h5A;
    txn(1, 0);
    rx_fifo_full = 1'b0;
    clear_err();

    push_tx(8'($urandom));
    mb[0] = 8'($urandom);
    txn(0, 5);
    push_tx(8'($urandom)); push_tx(8'($urandom));
    mb[0] = 8'hC3;
    txn(1, 0);

    push_tx(8'($urandom));
    cs = 1'b0;
    repeat (6) @(negedge clk);
    model_fetch(v);
    bit_xfer(1'b1, m);
    bit_xfer(1'b0, m);
    rst = 1'b0;
    cs = 1'b1;
    @(negedge clk);
    check_reset();
    exp_dout = 8'h00;
    exp_ovf = 1'b0;
    exp_unr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    push_tx(8'($urandom)); push_tx(8'($urandom));
    mb[0] = 8'h96;
    txn(1, 0);

    for (int t = 0; t < 8; t++) begin
      int n, fill, part;
      h = $urandom_range(4, 6);
      n = $urandom_range(1, 3);
      fill = $urandom_range(0, n + 1);
      for (int i = 0; i < fill; i++) push_tx(8'($urandom));
      for (int i = 0; i < 8; i++) mb[i] = 8'($urandom);
      part = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      rx_fifo_full = ($urandom_range(0, 3) == 0);
      clear_err();
      txn(n, part);
      rx_fifo_full = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
